// File: rtl/comm_pkg.sv
// Shared types and constants for the comm_slave command/response link.
package comm_pkg;

  localparam int UART_DATA_BITS   = 8;
  localparam int BAUD_DIV_DEFAULT = 2604;

  typedef enum logic {
    WAIT_HIGH = 1'b0,
    WAIT_LOW  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/comm_uart.sv
// 8N1 serial byte engine: one receiver and one transmitter that run independently.
module comm_uart
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic                      tx,
  input  logic                      trmt,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx_done,
  output logic                      tx_busy,
  output logic                      rdy,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      frm_err,
  input  logic                      clr_rdy
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL_LIM = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LIM = CW'(BAUD_DIV / 2 - 1);

  logic                      rx_p0, rx_p1, rx_p2;
  logic                      rx_busy;
  logic [CW-1:0]             rx_cnt;
  logic [3:0]                rx_bit;
  logic [UART_DATA_BITS-1:0] rx_sh;
  logic                      rx_tick;

  logic [CW-1:0]             tx_cnt;
  logic [3:0]                tx_bit;
  logic [UART_DATA_BITS:0]   tx_sh;
  logic                      tx_tick;

  assign rx_tick = rx_busy && (rx_cnt == ((rx_bit == 4'd0) ? HALF_LIM : FULL_LIM));
  assign tx_tick = tx_busy && (tx_cnt == FULL_LIM);

  // Start is a falling edge, so a line left low by a bad stop bit is not re-armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_p2   <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
      if (clr_rdy) rdy <= 1'b0;
      if (!rx_busy) begin
        if (rx_p2 && !rx_p1) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_tick) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd0) begin
          if (rx_p1) rx_busy <= 1'b0;
          else       rx_bit  <= 4'd1;
        end else if (rx_bit <= 4'd8) begin
          rx_bit <= rx_bit + 4'd1;
        end else begin
          rx_busy <= 1'b0;
          rx_bit  <= '0;
          rdy     <= 1'b1;
          frm_err <= !rx_p1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_tick && rx_bit >= 4'd1 && rx_bit <= 4'd8) rx_sh <= {rx_p1, rx_sh[UART_DATA_BITS-1:1]};
    if (rx_tick && rx_bit == 4'd9) rx_data <= rx_sh;
  end

  // tx_bit 0 is the start bit; the frame ends when the stop bit (index 9) expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (trmt) begin
          tx_busy <= 1'b1;
          tx      <= 1'b0;
          tx_cnt  <= '0;
          tx_bit  <= '0;
        end
      end else if (tx_tick) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
          tx      <= 1'b1;
        end else begin
          tx     <= tx_sh[0];
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!tx_busy && trmt)                tx_sh <= {1'b1, tx_data};
    else if (tx_tick && tx_bit != 4'd9)  tx_sh <= {1'b1, tx_sh[UART_DATA_BITS:1]};
  end

endmodule

// File: rtl/comm_slave.sv
// Two-byte command receiver and one-byte response sender over a UART link.
// Optional WAIT_LOW timeout is built when COMM_SLAVE_TIMEOUT_EN is defined.
module comm_slave
  import comm_pkg::*;
#(
  parameter int BAUD_DIV       = BAUD_DIV_DEFAULT,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        RX,
  output logic                        TX,
  output logic [2*UART_DATA_BITS-1:0] cmd,
  output logic                        cmd_rdy,
  input  logic                        clr_cmd_rdy,
  input  logic [UART_DATA_BITS-1:0]   resp,
  input  logic                        snd_resp,
  output logic                        resp_sent,
  output logic                        tx_busy
);

  logic                      rdy, frm_err, clr_rdy, consume, good;
  logic [UART_DATA_BITS-1:0] rx_data, high;
  rx_state_t                 state;

  comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst     (rst),
    .rx      (RX),
    .tx      (TX),
    .trmt    (snd_resp && !tx_busy),
    .tx_data (resp),
    .tx_done (resp_sent),
    .tx_busy (tx_busy),
    .rdy     (rdy),
    .rx_data (rx_data),
    .frm_err (frm_err),
    .clr_rdy (clr_rdy)
  );

  // rdy stays high for one cycle after clr_rdy is issued; masking prevents a second consume.
  assign consume = rdy && !clr_rdy;
  assign good    = consume && !frm_err;

`ifdef COMM_SLAVE_TIMEOUT_EN
  logic [31:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT_HIGH;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      clr_rdy <= 1'b0;
`ifdef COMM_SLAVE_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      clr_rdy <= consume;
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      case (state)
        WAIT_HIGH: begin
`ifdef COMM_SLAVE_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (good) begin
            high    <= rx_data;
            cmd_rdy <= 1'b0;
            state   <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (good) begin
            cmd     <= {high, rx_data};
            cmd_rdy <= 1'b1;
            state   <= WAIT_HIGH;
          end
`ifdef COMM_SLAVE_TIMEOUT_EN
          else if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            state   <= WAIT_HIGH;
          end
          tmo_cnt <= tmo_cnt + 32'd1;
`endif
        end
        default: state <= WAIT_HIGH;
      endcase
    end
  end

endmodule
